// File: rtl/seq_shifter.sv
// seq_shifter: iterative shift/rotate unit (SLL/SRL/SRA/ROR), one position per SHIFT cycle.
// Define SEQ_SHIFTER_STEP4_EN to step up to four positions per SHIFT cycle instead.
module seq_shifter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [SHW-1:0]   src1,
   input  logic [WIDTH-1:0] src2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] work_q;
   logic [SHW-1:0]   cnt_q;
   logic [1:0]       op_q;

   logic [SHW-1:0]   step;
   logic [WIDTH-1:0] work_d;
   logic             last;

   function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v, input logic [1:0] o);
      logic [WIDTH-1:0] r;
      case (o)
         2'b00:   r = {v[WIDTH-2:0], 1'b0};
         2'b01:   r = {1'b0, v[WIDTH-1:1]};
         2'b10:   r = {v[WIDTH-1], v[WIDTH-1:1]};
         default: r = {v[0], v[WIDTH-1:1]};
      endcase
      return r;
   endfunction

   always_comb begin
`ifdef SEQ_SHIFTER_STEP4_EN
      step = (cnt_q > SHW'(4)) ? SHW'(4) : cnt_q;
`else
      step = SHW'(1);
`endif
      // cnt_q is never zero while shifting, so this is the final step
      last   = (cnt_q <= step);
      work_d = work_q;
      for (int i = 0; i < 4; i++) begin
         if (SHW'(i) < step) work_d = shift1(work_d, op_q);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         work_q  <= '0;
         cnt_q   <= '0;
         op_q    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  work_q <= src2;
                  cnt_q  <= src1;
                  op_q   <= op;
                  busy   <= 1'b1;
                  if (src1 == '0) begin
                     state_q <= StDone;
                     done    <= 1'b1;
                     result  <= src2;
                  end else begin
                     state_q <= StShift;
                  end
               end
            end
            StShift: begin
               work_q <= work_d;
               cnt_q  <= cnt_q - step;
               if (last) begin
                  state_q <= StDone;
                  done    <= 1'b1;
                  result  <= work_d;
               end
            end
            StDone: begin
               state_q <= StIdle;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed and randomized checks of seq_shifter against an arithmetic model.
// Honours SEQ_SHIFTER_STEP4_EN for the expected latency.
module tb_seq_shifter;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [4:0]  src1;
   logic [31:0] src2;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int errors = 0;
   int checks = 0;

   seq_shifter #(.WIDTH(32), .SHW(5)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .src1   (src1),
      .src2   (src2),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] o, input int k, input logic [31:0] d);
      case (o)
         2'b00:   return d << k;
         2'b01:   return d >> k;
         2'b10:   return 32'($signed(d) >>> k);
         default: return (k == 0) ? d : ((d >> k) | (d << (32 - k)));
      endcase
   endfunction

   // Cycles with busy high: shifting cycles plus the DONE cycle.
   function automatic int busy_cycles(input int k);
`ifdef SEQ_SHIFTER_STEP4_EN
      return (k + 3) / 4 + 1;
`else
      return k + 1;
`endif
   endfunction

   // Issue one request; noise > 0 pulses a conflicting start in that busy cycle.
   task automatic run_op(input string tag, input logic [1:0] o, input int k,
                         input logic [31:0] d, input int noise);
      logic [31:0] exp;
      int lat, busy_cnt, done_cnt, done_at;
      exp = model(o, k, d);
      lat = busy_cycles(k);
      busy_cnt = 0;
      done_cnt = 0;
      done_at  = 0;
      @(negedge clk);
      start = 1'b1;
      op    = o;
      src1  = 5'(k);
      src2  = d;
      for (int c = 1; c <= lat + 1; c++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            done_at = c;
            check({tag, "/result"}, result, exp);
         end
         start = (c == noise);
         if (c == noise) begin
            op   = 2'b01;
            src1 = 5'd1;
            src2 = 32'hFFFF_FFFF;
         end else begin
            op   = 2'($urandom_range(3));
            src1 = 5'($urandom_range(31));
            src2 = $urandom;
         end
      end
      start = 1'b0;
      check({tag, "/busy_cycles"}, 32'(busy_cnt), 32'(lat));
      check({tag, "/done_pulses"}, 32'(done_cnt), 32'd1);
      check({tag, "/done_cycle"}, 32'(done_at), 32'(lat));
      @(negedge clk);
      check({tag, "/held"}, result, exp);
   endtask

   initial begin
      rst   = 1'b0;
      start = 1'b0;
      op    = 2'b00;
      src1  = '0;
      src2  = '0;
      repeat (2) @(negedge clk);
      check("reset/busy", 32'(busy), 32'd0);
      check("reset/done", 32'(done), 32'd0);
      check("reset/result", result, 32'd0);
      rst = 1'b1;

      run_op("sll31", 2'b00, 31, 32'h0000_0003, 0);
      check("sll31/value", result, 32'h8000_0000);
      run_op("ror1", 2'b11, 1, 32'h0000_0003, 0);
      check("ror1/value", result, 32'h8000_0001);
      run_op("ror8", 2'b11, 8, 32'h1234_5678, 0);
      check("ror8/value", result, 32'h7812_3456);
      run_op("sra4", 2'b10, 4, 32'h8000_0000, 0);
      check("sra4/value", result, 32'hF800_0000);
      run_op("srl4", 2'b01, 4, 32'h8000_0000, 0);
      check("srl4/value", result, 32'h0800_0000);
      run_op("zero", 2'b00, 0, 32'hDEAD_BEEF, 0);
      check("zero/value", result, 32'hDEAD_BEEF);
      run_op("busy_start", 2'b00, 5, 32'h0000_0001, 2);
      check("busy_start/value", result, 32'h0000_0020);

      // Abort mid-operation with an asynchronous reset between clock edges.
      @(negedge clk);
      start = 1'b1;
      op    = 2'b00;
      src1  = 5'd20;
      src2  = 32'hA5A5_0F0F;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("abort/busy", 32'(busy), 32'd0);
      check("abort/done", 32'(done), 32'd0);
      check("abort/result", result, 32'd0);
      repeat (3) @(negedge clk);
      check("abort/done_held", 32'(done), 32'd0);
      rst = 1'b1;
      run_op("post_reset", 2'b11, 1, 32'h0000_0001, 0);
      check("post_reset/value", result, 32'h8000_0000);

      for (int n = 0; n < 40; n++) begin
         logic [1:0]  ro;
         int          rk;
         logic [31:0] rd;
         int          rn;
         ro = 2'($urandom_range(3));
         rk = (n == 0) ? 0 : (n == 1) ? 31 : int'($urandom_range(31));
         rd = $urandom;
         rn = ($urandom_range(1) == 1) ? int'($urandom_range(busy_cycles(rk), 1)) : 0;
         run_op("random", ro, rk, rd, rn);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
